// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, prefix FSM states and event type for the PS/2 key decoder
package ps2_pkg;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS = 8'h58;
  localparam logic [7:0] DISCARD_BYTES [8] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } evt_t;
  function automatic logic is_discard(input logic [7:0] b);
    is_discard = 1'b0;
    for (int i = 0; i < 8; i++) if (b == DISCARD_BYTES[i]) is_discard = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational set-2 scan code to ASCII translation
// Ports: i_code scan code, i_shift shift held, i_caps caps-lock state, o_ascii result (0x00 if none).
module ps2_ascii_lut (
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii
);
  logic w_up;
  assign w_up = i_shift ^ i_caps;
  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = w_up ? "A" : "a";
      8'h32: o_ascii = w_up ? "B" : "b";
      8'h21: o_ascii = w_up ? "C" : "c";
      8'h23: o_ascii = w_up ? "D" : "d";
      8'h24: o_ascii = w_up ? "E" : "e";
      8'h2B: o_ascii = w_up ? "F" : "f";
      8'h34: o_ascii = w_up ? "G" : "g";
      8'h33: o_ascii = w_up ? "H" : "h";
      8'h43: o_ascii = w_up ? "I" : "i";
      8'h3B: o_ascii = w_up ? "J" : "j";
      8'h42: o_ascii = w_up ? "K" : "k";
      8'h4B: o_ascii = w_up ? "L" : "l";
      8'h3A: o_ascii = w_up ? "M" : "m";
      8'h31: o_ascii = w_up ? "N" : "n";
      8'h44: o_ascii = w_up ? "O" : "o";
      8'h4D: o_ascii = w_up ? "P" : "p";
      8'h15: o_ascii = w_up ? "Q" : "q";
      8'h2D: o_ascii = w_up ? "R" : "r";
      8'h1B: o_ascii = w_up ? "S" : "s";
      8'h2C: o_ascii = w_up ? "T" : "t";
      8'h3C: o_ascii = w_up ? "U" : "u";
      8'h2A: o_ascii = w_up ? "V" : "v";
      8'h1D: o_ascii = w_up ? "W" : "w";
      8'h22: o_ascii = w_up ? "X" : "x";
      8'h35: o_ascii = w_up ? "Y" : "y";
      8'h1A: o_ascii = w_up ? "Z" : "z";
      8'h45: o_ascii = i_shift ? ")" : "0";
      8'h16: o_ascii = i_shift ? "!" : "1";
      8'h1E: o_ascii = i_shift ? "@" : "2";
      8'h26: o_ascii = i_shift ? "#" : "3";
      8'h25: o_ascii = i_shift ? "$" : "4";
      8'h2E: o_ascii = i_shift ? "%" : "5";
      8'h36: o_ascii = i_shift ? "^" : "6";
      8'h3D: o_ascii = i_shift ? "&" : "7";
      8'h3E: o_ascii = i_shift ? "*" : "8";
      8'h46: o_ascii = i_shift ? "(" : "9";
      8'h29: o_ascii = 8'h20;
      8'h5A: o_ascii = 8'h0D;
      8'h66: o_ascii = 8'h08;
      default: o_ascii = 8'h00;
    endcase
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 byte stream to key events with modifier tracking and event FIFO
// Ports: clk/reset (async, active-high); rx_data/rx_valid byte strobe in;
//   evt_valid/evt_ready handshake with evt_code/evt_ext/evt_break/evt_ascii head event;
//   shift_held, caps_lock modifier state; overflow sticky drop flag.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  state_t r_state, w_next;
  logic w_emit, w_ext, w_brk, w_repeat, w_accept, w_full, w_pop, w_wr, w_mod;
  logic r_lshift, r_rshift, r_caps, r_ovf;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0] w_lut_ascii;
  evt_t r_mem [FIFO_DEPTH];
  evt_t w_evt, w_head;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_ext = 1'b0;
    w_brk = 1'b0;
    if (rx_valid && !is_discard(rx_data))
      case (r_state)
        S_IDLE: begin
          w_next = rx_data == PFX_EXT ? S_E0 : rx_data == PFX_BRK ? S_F0 : S_IDLE;
          w_emit = rx_data != PFX_EXT && rx_data != PFX_BRK;
        end
        S_E0: begin
          w_next = rx_data == PFX_BRK ? S_E0F0 : rx_data == PFX_EXT ? S_E0 : S_IDLE;
          w_emit = rx_data != PFX_EXT && rx_data != PFX_BRK;
          w_ext = 1'b1;
        end
        S_F0: begin
          w_next = S_IDLE;
          w_emit = rx_data != PFX_EXT && rx_data != PFX_BRK;
          w_brk = 1'b1;
        end
        default: begin
          w_next = S_IDLE;
          w_emit = rx_data != PFX_EXT && rx_data != PFX_BRK;
          w_ext = 1'b1;
          w_brk = 1'b1;
        end
      endcase
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic r_last_vld, r_last_ext, w_same;
  logic [7:0] r_last_code;
  assign w_same = r_last_vld && r_last_code == rx_data && r_last_ext == w_ext;
  assign w_repeat = w_emit && !w_brk && w_same;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last_vld <= 1'b0;
      r_last_ext <= 1'b0;
      r_last_code <= 8'h00;
    end else if (w_emit && !w_brk) begin
      r_last_vld <= 1'b1;
      r_last_ext <= w_ext;
      r_last_code <= rx_data;
    end else if (w_emit && w_same) r_last_vld <= 1'b0;
`else
  assign w_repeat = 1'b0;
`endif
  ps2_ascii_lut u_lut (
    .i_code (rx_data),
    .i_shift(shift_held),
    .i_caps (r_caps),
    .o_ascii(w_lut_ascii)
  );
  always_comb begin
    w_evt.code = rx_data;
    w_evt.ext = w_ext;
    w_evt.brk = w_brk;
    w_evt.ascii = (w_ext || w_brk) ? 8'h00 : w_lut_ascii;
  end
  assign w_accept = w_emit && !w_repeat;
  assign w_full = r_count == CW'(FIFO_DEPTH);
  assign w_pop = evt_valid && evt_ready;
  assign w_wr = w_accept && (!w_full || w_pop);
  assign w_mod = w_accept && !w_ext;
  // Modifiers follow every accepted event, even one dropped on a full FIFO.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps <= 1'b0;
    end else begin
      if (w_mod && rx_data == KEY_LSHIFT) r_lshift <= !w_brk;
      if (w_mod && rx_data == KEY_RSHIFT) r_rshift <= !w_brk;
      if (w_mod && !w_brk && rx_data == KEY_CAPS) r_caps <= !r_caps;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_accept && !w_wr) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= w_evt;
  assign evt_valid = r_count != '0;
  assign w_head = evt_valid ? r_mem[r_rd_ptr] : '0;
  assign evt_code = w_head.code;
  assign evt_ext = w_head.ext;
  assign evt_break = w_head.brk;
  assign evt_ascii = w_head.ascii;
  assign shift_held = r_lshift | r_rshift;
  assign caps_lock = r_caps;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized and directed checks of ps2_key_decoder against a queue-based model
module tb_ps2_key_decoder;
  localparam int DEPTH = 4;
  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
    8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] JUNK [8] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  typedef struct {
    logic [7:0] code;
    bit ext;
    bit brk;
    logic [7:0] ascii;
  } ev_t;
  logic clk, reset, rx_valid, evt_valid, evt_ready, evt_ext, evt_break, shift_held, caps_lock, overflow;
  logic [7:0] rx_data, evt_code, evt_ascii;
  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .evt_ascii(evt_ascii), .shift_held(shift_held), .caps_lock(caps_lock), .overflow(overflow)
  );
  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;
  ev_t q[$];
  bit m_ext, m_brk, m_lsh, m_rsh, m_caps, m_ovf, last_vld, last_ext;
  logic [7:0] last_code;
  string shifted_digits = ")!@#$%^&*(";
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] ref_ascii(input logic [7:0] b);
    bit sh = m_lsh | m_rsh;
    for (int i = 0; i < 26; i++) if (b == LETTERS[i]) return 8'((sh ^ m_caps) ? 8'h41 + i : 8'h61 + i);
    for (int i = 0; i < 10; i++) if (b == DIGITS[i]) return sh ? shifted_digits[i] : 8'(8'h30 + i);
    return b == 8'h29 ? 8'h20 : b == 8'h5A ? 8'h0D : b == 8'h66 ? 8'h08 : 8'h00;
  endfunction
  task automatic model_reset();
    q.delete();
    {m_ext, m_brk, m_lsh, m_rsh, m_caps, m_ovf, last_vld, last_ext} = '0;
    last_code = 8'h00;
  endtask
  task automatic model_emit(input logic [7:0] b);
    ev_t ev;
    bit rep = 0;
    bit pop = q.size() != 0 && evt_ready;
    bit full = q.size() == DEPTH;
    ev.code = b;
    ev.ext = m_ext;
    ev.brk = m_brk;
    ev.ascii = (m_ext || m_brk) ? 8'h00 : ref_ascii(b);
`ifdef PS2_TYPEMATIC_FILTER_EN
    rep = !m_brk && last_vld && last_code == b && last_ext == m_ext;
    if (!m_brk) begin
      last_vld = 1;
      last_code = b;
      last_ext = m_ext;
    end else if (last_vld && last_code == b && last_ext == m_ext) last_vld = 0;
`endif
    if (pop) q.delete(0);
    if (!rep) begin
      if (!full || pop) q.push_back(ev);
      else m_ovf = 1;
      if (!m_ext && b == 8'h12) m_lsh = !m_brk;
      if (!m_ext && b == 8'h59) m_rsh = !m_brk;
      if (!m_ext && !m_brk && b == 8'h58) m_caps = !m_caps;
    end
  endtask
  task automatic model_step();
    logic [7:0] b = rx_data;
    bit emitted = 0;
    if (rx_valid && !(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
      if (b == 8'hE0) begin
        if (m_brk) {m_ext, m_brk} = 2'b00;
        else m_ext = 1;
      end else if (b == 8'hF0) begin
        if (m_brk) {m_ext, m_brk} = 2'b00;
        else m_brk = 1;
      end else begin
        model_emit(b);
        emitted = 1;
        {m_ext, m_brk} = 2'b00;
      end
    end
    if (!emitted && q.size() != 0 && evt_ready) q.delete(0);
  endtask
  task automatic step(input logic [7:0] b, input bit v, input bit r);
    rx_data = b;
    rx_valid = v;
    evt_ready = r;
    @(posedge clk);
    model_step();
    #1;
    rx_valid = 0;
    evt_ready = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask
  always @(negedge clk) if (chk_en) begin
    check("evt_valid", evt_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("evt_code", evt_code, q[0].code);
      check("evt_ext", evt_ext, q[0].ext);
      check("evt_break", evt_break, q[0].brk);
      check("evt_ascii", evt_ascii, q[0].ascii);
    end
    check("shift_held", shift_held, m_lsh | m_rsh);
    check("caps_lock", caps_lock, m_caps);
    check("overflow", overflow, m_ovf);
  end
  initial begin
    logic [7:0] codes [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    int makes;
    reset = 1;
    rx_data = 0;
    rx_valid = 0;
    evt_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_ascii", evt_ascii, 0);
    check("rst_flags", {evt_ext, evt_break, shift_held, caps_lock, overflow}, 0);
    reset = 0;
    step(8'h1C, 1, 0);
    check("a_code", evt_code, 8'h1C);
    check("a_flags", {evt_ext, evt_break}, 0);
    check("a_ascii", evt_ascii, 8'h61);
    do_reset();
    step(8'h12, 1, 1);
    check("shmk_code", evt_code, 8'h12);
    check("shmk_held", shift_held, 1);
    step(8'h1C, 1, 1);
    check("A_ascii", evt_ascii, 8'h41);
    step(8'hF0, 1, 1);
    step(8'h12, 1, 1);
    check("shbrk_break", evt_break, 1);
    check("shbrk_held", shift_held, 0);
    do_reset();
    step(8'hE0, 1, 0);
    step(8'hF0, 1, 0);
    step(8'h75, 1, 0);
    check("ext_code", evt_code, 8'h75);
    check("ext_flags", {evt_ext, evt_break}, 2'b11);
    check("ext_ascii", evt_ascii, 0);
    step(0, 0, 1);
    check("ext_single", evt_valid, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(codes[i], 1, 0);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", evt_code, codes[i]);
      step(0, 0, 1);
    end
    check("ovf_drained", evt_valid, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(codes[i], 1, 0);
    step(8'h24, 1, 1);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_head", evt_code, 8'h32);
    do_reset();
    step(8'h58, 1, 0);
    step(8'h58, 1, 0);
    step(8'hF0, 1, 0);
    step(8'h58, 1, 0);
    makes = 0;
    for (int i = 0; i < 8 && evt_valid; i++) begin
      if (!evt_break) makes++;
      step(0, 0, 1);
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("caps_state", caps_lock, 1);
    check("caps_makes", 8'(makes), 1);
`else
    check("caps_state", caps_lock, 0);
    check("caps_makes", 8'(makes), 2);
`endif
    do_reset();
    step(8'hE0, 1, 0);
    do_reset();
    step(8'h1C, 1, 0);
    check("rstmid_code", evt_code, 8'h1C);
    check("rstmid_ext", evt_ext, 0);
    step(0, 0, 1);
    check("rstmid_single", evt_valid, 0);
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        logic [7:0] b;
        int k = $urandom_range(0, 9);
        b = k == 0 ? 8'hE0 : k == 1 ? 8'hF0 : k == 2 ? JUNK[$urandom_range(0, 7)] :
            k == 3 ? ($urandom_range(0, 1) ? 8'h12 : 8'h59) : k == 4 ? 8'h58 :
            k == 5 ? DIGITS[$urandom_range(0, 9)] : k < 8 ? LETTERS[$urandom_range(0, 25)] : 8'($urandom);
        step(b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) < ph + 1);
        if ($urandom_range(0, 399) == 0) do_reset();
      end
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 rx_data  input  8  received scan-code byte from PS/2 receiver.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data valid only in that cycle.
REQ-006 evt_valid  output  1  FIFO head holds an event.
REQ-007 evt_ready  input  1  consumer accepts head when evt_valid&evt_ready.
REQ-008 evt_code  output  8  head event base scan code (prefixes stripped).
REQ-009 evt_ext  output  1  head event carried E0 prefix.
REQ-010 evt_break  output  1  head event is key release (F0 seen).
REQ-011 evt_ascii  output  8  head event ASCII; 0x00 if untranslatable, break, or extended.
REQ-012 shift_held  output  1  either shift key (0x12, 0x59, non-ext) currently held.
REQ-013 caps_lock  output  1  caps-lock toggle state.
REQ-014 overflow  output  1  sticky: an event was dropped on full FIFO.

Function
REQ-015 Prefix FSM states IDLE, E0, F0, E0F0; evaluated only on rx_valid cycles.
REQ-016 IDLE: 0xE0->E0; 0xF0->F0; other byte->emit make, ext=0.
REQ-017 E0: 0xF0->E0F0; 0xE0 stays E0; other->emit make, ext=1, ->IDLE.
REQ-018 F0: 0xE0 or 0xF0->IDLE, nothing emitted (protocol error); other->emit break, ext=0, ->IDLE.
REQ-019 E0F0: 0xE0/0xF0->IDLE, nothing emitted; other->emit break, ext=1, ->IDLE.
REQ-020 Bytes 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF discarded in any state; FSM unchanged.
REQ-021 Emitted event written to FIFO on the clock edge ending the rx_valid cycle; evt_valid high next cycle (1-cycle latency).
REQ-022 shift_held/caps_lock update on the same edge as the write, before ASCII of later events; ASCII computed with state prior to the current byte.
REQ-023 Non-ext make 0x12/0x59 sets its shift bit; matching break clears; shift_held = OR.
REQ-024 Non-ext make 0x58 toggles caps_lock; break ignored.
REQ-025 ASCII: letters upper iff shift_held XOR caps_lock; digits 0x16..0x46 give '0'-'9', shifted "!@#$%^&*()"; 0x29->0x20, 0x5A->0x0D, 0x66->0x08; all else 0x00.
REQ-026 FIFO full with no pop this cycle: event dropped, overflow set; modifier/caps state still updates.
REQ-027 Full with simultaneous pop: event accepted, no overflow.
REQ-028 Empty with write: evt_valid next cycle; no same-cycle bypass.
REQ-029 evt_* outputs stable while evt_valid&!evt_ready.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-031 Reset: FSM IDLE, FIFO empty, evt_valid=0, evt_code/evt_ascii=0x00, evt_ext/evt_break=0, shift_held=0, caps_lock=0, overflow=0.
REQ-032 Reset mid-sequence (e.g. after 0xE0) discards the pending prefix and all queued events.

Configuration
REQ-033 Macro PS2_TYPEMATIC_FILTER_EN defined: make with same {code,ext} as the last accepted make, with no intervening break of that key, is suppressed (not written, no caps toggle, no overflow).
REQ-034 Macro undefined: every make emitted; repeated 0x58 toggles caps each repeat.

Structure
REQ-035 Shared package ps2_pkg holds prefix constants (0xE0, 0xF0), discard-byte list, modifier codes, FSM state enum, event struct type.
REQ-036 Sub-module ps2_ascii_lut: combinational {code, shift, caps}->ASCII.

Verification
REQ-037 Bytes 0x1C -> event code 0x1C, ext 0, break 0, ascii 0x61.
REQ-038 0x12, 0x1C, 0xF0 0x12 -> shift make, 'A' (0x41), shift break; shift_held 1 then 0.
REQ-039 0xE0 0xF0 0x75 -> single event code 0x75, ext 1, break 1, ascii 0x00.
REQ-040 evt_ready=0, FIFO_DEPTH+1 makes -> first FIFO_DEPTH kept in order, overflow=1; full plus simultaneous pop accepts.
REQ-041 0x58 0x58 0xF0 0x58 with filter defined -> caps_lock 1, one make event; undefined -> caps_lock 0, two makes.
REQ-042 0xE0 then reset then 0x1C -> non-ext make 0x1C, FIFO previously empty.
